// File: rtl/risc_toy_dbus_responder.sv
// Data-bus slave for RISC_TOY: on-chip data RAM plus MMIO bank (GPIO, timer/compare, status, scratch).
// Latency: reads captured into DRDATA at the request edge (one cycle); writes land at the request edge.
// Backpressure: none, every request is accepted in the cycle it is presented; the core is never stalled.
module risc_toy_dbus_responder #(
    parameter int          AW        = 10,
    parameter logic [31:0] RSTN_GPIO = 32'h0
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic [31:0] GPIO_OUT,
    input  logic [31:0] GPIO_IN,
    output logic        IRQ,
    output logic        BUS_ERR
);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];
    logic          is_mmio;
    logic [2:0]    sel;
    logic [AW-1:0] ram_idx;
    logic          wr_ram;
    logic          wr_mmio;
    logic          rd_req;
    logic          unused_addr_bits;

    logic [31:0]   drdata_q;
    logic [31:0]   gpio_out_q;
    logic [31:0]   gpio_sync1_q;
    logic [31:0]   gpio_sync2_q;
    logic [31:0]   tcnt_q;
    logic [31:0]   tcmp_q;
    logic [2:0]    tctrl_q;
    logic          match_q;
    logic [31:0]   scratch_q;
    logic          bus_err_q;

    logic [31:0]   mmio_rdata;
    logic          timer_hit;
    logic          status_clr;

    assign is_mmio          = DADDR[29];
    assign sel              = DADDR[2:0];
    assign ram_idx          = DADDR[AW-1:0];
    assign wr_ram           = DREQ & DRW & ~is_mmio;
    assign wr_mmio          = DREQ & DRW & is_mmio;
    assign rd_req           = DREQ & ~DRW;
    assign unused_addr_bits = ^DADDR[28:3];

    assign timer_hit  = tctrl_q[0] && (tcnt_q == tcmp_q);
    assign status_clr = wr_mmio && (sel == 3'd5) && DWDATA[0];

    always_comb begin
        mmio_rdata = '0;
        case (sel)
            3'd0:    mmio_rdata = gpio_out_q;
            3'd1:    mmio_rdata = gpio_sync2_q;
            3'd2:    mmio_rdata = tcnt_q;
            3'd3:    mmio_rdata = tcmp_q;
            3'd4:    mmio_rdata = {29'd0, tctrl_q};
            3'd5:    mmio_rdata = {31'd0, match_q};
            3'd6:    mmio_rdata = scratch_q;
            default: mmio_rdata = '0;
        endcase
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (wr_ram) begin
            mem[ram_idx] <= DWDATA;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            drdata_q     <= '0;
            gpio_out_q   <= RSTN_GPIO;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            tcnt_q       <= '0;
            tcmp_q       <= '0;
            tctrl_q      <= '0;
            match_q      <= 1'b0;
            scratch_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            gpio_sync1_q <= GPIO_IN;
            gpio_sync2_q <= gpio_sync1_q;
            bus_err_q    <= DREQ && is_mmio && (sel == 3'd7);

            if (rd_req) begin
                drdata_q <= is_mmio ? mmio_rdata : mem[ram_idx];
            end

            if (tctrl_q[0]) begin
                tcnt_q <= (tctrl_q[1] && timer_hit) ? 32'd0 : tcnt_q + 32'd1;
            end
            // A fresh match outranks a same-cycle software clear.
            match_q <= timer_hit | (match_q & ~status_clr);

            // Placed after the timer update so a software TCNT write takes priority.
            if (wr_mmio) begin
                case (sel)
                    3'd0:    gpio_out_q <= DWDATA;
                    3'd2:    tcnt_q     <= DWDATA;
                    3'd3:    tcmp_q     <= DWDATA;
                    3'd4:    tctrl_q    <= DWDATA[2:0];
                    3'd6:    scratch_q  <= DWDATA;
                    default: ;
                endcase
            end
        end
    end

    assign DRDATA   = drdata_q;
    assign GPIO_OUT = gpio_out_q;
    assign IRQ      = match_q & tctrl_q[2];
    assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_risc_toy_dbus_responder.sv
// Randomised bench for risc_toy_dbus_responder with a behavioural register-map model and
// an expectation queue drained by an independent monitor.
module tb_risc_toy_dbus_responder;
    localparam int          AW = 10;
    localparam logic [31:0] RG = 32'hC0DE_0001;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        DREQ = 1'b0;
    logic        DRW = 1'b0;
    logic [29:0] DADDR = '0;
    logic [31:0] DWDATA = '0;
    logic [31:0] GPIO_IN = '0;
    logic [31:0] DRDATA;
    logic [31:0] GPIO_OUT;
    logic        IRQ;
    logic        BUS_ERR;

    risc_toy_dbus_responder #(.AW(AW), .RSTN_GPIO(RG)) dut (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .GPIO_OUT(GPIO_OUT), .GPIO_IN(GPIO_IN),
        .IRQ(IRQ), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
        logic [31:0] gpio;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];

    // Reference model of the architectural state visible to software.
    logic [31:0] m_ram [0:(1<<AW)-1];
    logic [31:0] m_gpio = RG;
    logic [31:0] m_tcnt = 0, m_tcmp = 0, m_scr = 0, m_last_rd = 0;
    logic [2:0]  m_tctrl = 0;
    logic        m_match = 0;
    logic [31:0] gin_hist[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // GPIO_IN is readable two edges after it is sampled.
    function automatic logic [31:0] m_gpio_in();
        if (gin_hist.size() < 2) return 32'd0;
        return gin_hist[gin_hist.size()-2];
    endfunction

    function automatic logic [31:0] m_read(input logic [29:0] a);
        if (!a[29]) return m_ram[a[AW-1:0]];
        case (a[2:0])
            3'd0: return m_gpio;
            3'd1: return m_gpio_in();
            3'd2: return m_tcnt;
            3'd3: return m_tcmp;
            3'd4: return {29'd0, m_tctrl};
            3'd5: return {31'd0, m_match};
            3'd6: return m_scr;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input bit req, input bit rw, input logic [29:0] a,
                          input logic [31:0] d, input logic [31:0] gin);
        bit          wr  = req && rw;
        bit          hit = m_tctrl[0] && (m_tcnt == m_tcmp);
        logic [31:0] nxt = m_tcnt;
        if (m_tctrl[0]) nxt = (m_tctrl[1] && hit) ? 32'd0 : m_tcnt + 32'd1;
        if (hit) m_match = 1'b1;
        else if (wr && a[29] && a[2:0] == 3'd5 && d[0]) m_match = 1'b0;
        if (wr && !a[29]) m_ram[a[AW-1:0]] = d;
        if (wr && a[29]) begin
            case (a[2:0])
                3'd0: m_gpio = d;
                3'd2: nxt = d;
                3'd3: m_tcmp = d;
                3'd4: m_tctrl = d[2:0];
                3'd6: m_scr = d;
                default: ;
            endcase
        end
        m_tcnt = nxt;
        gin_hist.push_back(gin);
    endtask

    // Called at posedge+1; drives one cycle of bus traffic and queues what the DUT must show.
    task automatic cyc(input bit req, input bit rw, input logic [29:0] a,
                       input logic [31:0] d, input logic [31:0] gin);
        exp_t e;
        DREQ = req; DRW = rw; DADDR = a; DWDATA = d; GPIO_IN = gin;
        if (req && !rw) m_last_rd = m_read(a);
        e.rd   = m_last_rd;
        e.berr = req && a[29] && (a[2:0] == 3'd7);
        @(posedge CLK);
        m_step(req, rw, a, d, gin);
        e.gpio = m_gpio;
        e.irq  = m_match & m_tctrl[2];
        exp_q.push_back(e);
        #1;
        DREQ = 1'b0;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, GPIO_IN);
    endtask

    task automatic rd(input logic [29:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, GPIO_IN);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 30'd0, 32'd0, GPIO_IN);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("drdata", DRDATA, e.rd);
                check("bus_err", {31'd0, BUS_ERR}, {31'd0, e.berr});
                check("gpio_out", GPIO_OUT, e.gpio);
                check("irq", {31'd0, IRQ}, {31'd0, e.irq});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    localparam logic [29:0] GPIO_A = 30'h2000_0000;
    localparam logic [29:0] GIN_A  = 30'h2000_0001;
    localparam logic [29:0] TCNT_A = 30'h2000_0002;
    localparam logic [29:0] TCMP_A = 30'h2000_0003;
    localparam logic [29:0] TCTL_A = 30'h2000_0004;
    localparam logic [29:0] STAT_A = 30'h2000_0005;
    localparam logic [29:0] SCR_A  = 30'h2000_0006;
    localparam logic [29:0] UNM_A  = 30'h2000_0007;

    initial begin : stimulus
        logic [29:0] a;
        logic [31:0] d;
        logic [31:0] gin;
        int r;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_drdata", DRDATA, 32'd0);
        check("rst_gpio_out", GPIO_OUT, RG);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_bus_err", {31'd0, BUS_ERR}, 32'd0);
        RSTN = 1'b1;

        for (int i = 0; i < 16; i++) wr(30'(i), $urandom);

        // RAM write/read and aliasing
        wr(30'h005, 32'hDEAD_BEEF);
        rd(30'h005);
        rd(30'h405);
        rd(30'h1FFF_FC05);

        // GPIO path
        wr(GPIO_A, 32'h0000_A5A5);
        cyc(1'b0, 1'b0, 30'd0, 32'd0, 32'h0000_1234);
        idle(2);
        rd(GIN_A);
        wr(GIN_A, 32'hFFFF_FFFF);
        rd(GIN_A);
        rd(GPIO_A);
        wr(SCR_A, 32'h1357_9BDF);
        rd(SCR_A);

        // Compare with IRQ enabled, then W1C
        wr(TCMP_A, 32'd5);
        wr(TCTL_A, 32'd5);
        for (int i = 0; i < 8; i++) rd(TCNT_A);
        rd(STAT_A);
        wr(STAT_A, 32'd0);
        rd(STAT_A);
        wr(STAT_A, 32'd1);
        rd(STAT_A);
        rd(TCTL_A);

        // Auto-clear sequence 0,1,2,3,0,...
        wr(TCTL_A, 32'd0);
        wr(TCNT_A, 32'd0);
        wr(TCMP_A, 32'd3);
        wr(STAT_A, 32'd1);
        wr(TCTL_A, 32'd3);
        for (int i = 0; i < 9; i++) rd(TCNT_A);

        // Wrap at all-ones
        wr(TCTL_A, 32'd0);
        wr(TCNT_A, 32'hFFFF_FFFF);
        wr(TCMP_A, 32'd7);
        wr(TCTL_A, 32'd1);
        for (int i = 0; i < 3; i++) rd(TCNT_A);

        // Set-vs-clear and write-vs-increment collisions
        wr(TCTL_A, 32'd0);
        wr(TCNT_A, 32'd20);
        wr(TCMP_A, 32'd20);
        wr(STAT_A, 32'd1);
        wr(TCTL_A, 32'd5);
        wr(STAT_A, 32'd1);
        rd(STAT_A);
        wr(TCNT_A, 32'd100);
        rd(TCNT_A);

        // Unmapped register
        rd(UNM_A);
        idle(1);
        wr(30'h3FFF_FFFF, 32'hFFFF_FFFF);
        rd(30'h2000_000F);

        // Randomised traffic over aliased RAM and the whole MMIO window
        gin = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            a = 30'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a[29] = 1'b0;
                a[AW-1:0] = AW'($urandom_range(0, 15));
            end else begin
                a[29] = 1'b1;
            end
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) gin = $urandom;
            cyc(r >= 2, r >= 6, a, d, gin);
        end

        // Asynchronous reset in the middle of a pending read
        wr(GPIO_A, 32'h0000_A5A5);
        wr(30'h005, 32'hDEAD_BEEF);
        rd(30'h005);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        DREQ = 1'b1; DRW = 1'b0; DADDR = GPIO_A;
        #2;
        RSTN = 1'b0;
        #1;
        check("async_rst_drdata", DRDATA, 32'd0);
        check("async_rst_gpio_out", GPIO_OUT, RG);
        check("async_rst_irq", {31'd0, IRQ}, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_read_discarded", DRDATA, 32'd0);
        DREQ = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
